// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver, oversampled by OVERSAMPLE, with a host ready/read handshake.
// Optional feature macro RX_GLITCH_FILTER_EN: every bit value becomes a 2-of-3 majority vote.
module uart_receiver #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       bclk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rd,
    output logic [7:0] d_out,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TickLast = TW'(OVERSAMPLE - 1);

`ifdef RX_GLITCH_FILTER_EN
    // The vote completes one tick after the nominal mid-bit point, so each decision
    // slides by one tick and DATA starts with its counter already advanced by one.
    localparam logic [TW-1:0] StartDec  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] StartNext = TW'(1);
    localparam logic [TW-1:0] BitDec    = '0;
`else
    localparam logic [TW-1:0] StartDec  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] StartNext = '0;
    localparam logic [TW-1:0] BitDec    = TickLast;
`endif

    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_bad_oversample
        $error("uart_receiver: OVERSAMPLE must be even and at least 4");
    end

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [TW-1:0] tick_next;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    rsr_q, rsr_d;
    logic [7:0]    rhr_q, rhr_d;
    logic          ready_q, ready_d;
    logic          ferr_q, ferr_d;
    logic          oerr_q, oerr_d;

    logic          sync1_q;
    logic          rx_s_q;
    logic          rx_dly_q;
    logic          sample;
    logic          fall;
    logic          frame_done;
    logic          rd_ack;

    // Two-flop synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            rx_s_q   <= 1'b1;
            rx_dly_q <= 1'b1;
        end else begin
            sync1_q  <= rx_in;
            rx_s_q   <= sync1_q;
            rx_dly_q <= rx_s_q;
        end
    end

`ifdef RX_GLITCH_FILTER_EN
    logic rx_dly2_q;

    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            rx_dly2_q <= 1'b1;
        end else begin
            rx_dly2_q <= rx_dly_q;
        end
    end

    assign sample = (rx_s_q & rx_dly_q) | (rx_s_q & rx_dly2_q) | (rx_dly_q & rx_dly2_q);
`else
    assign sample = rx_s_q;
`endif

    // Requiring the delayed copy to be high keeps a held-low line from retriggering.
    assign fall      = rx_dly_q & ~rx_s_q;
    assign tick_next = (tick_q == TickLast) ? '0 : tick_q + TW'(1);

    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            rsr_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            rsr_q   <= rsr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        rsr_d      = rsr_q;
        frame_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                tick_d = '0;
                if (fall) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                tick_d = tick_q + TW'(1);
                if (tick_q == StartDec) begin
                    tick_d  = StartNext;
                    bit_d   = '0;
                    state_d = sample ? StIdle : StData;
                end
            end
            StData: begin
                tick_d = tick_next;
                if (tick_q == BitDec) begin
                    rsr_d = {sample, rsr_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                tick_d = tick_next;
                if (tick_q == BitDec) begin
                    frame_done = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            rhr_q   <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            rhr_q   <= rhr_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    always_comb begin
        rhr_d   = rhr_q;
        ready_d = ready_q;
        ferr_d  = ferr_q;
        oerr_d  = oerr_q;
        rd_ack  = rd & ready_q;

        if (rd_ack) begin
            ready_d = 1'b0;
            ferr_d  = 1'b0;
            oerr_d  = 1'b0;
        end

        // A read in the completion cycle frees RHR, so the new byte is taken instead of dropped.
        if (frame_done) begin
            if (ready_q && !rd) begin
                oerr_d = 1'b1;
            end else begin
                rhr_d   = rsr_q;
                ferr_d  = ~sample;
                ready_d = 1'b1;
            end
        end
    end

    assign d_out       = rhr_q;
    assign rx_ready    = ready_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;
    assign rx_busy     = (state_q != StIdle);

    // Error flags only ever accompany an unread byte.
    assert property (@(posedge bclk) disable iff (reset) !ready_q |-> (!ferr_q && !oerr_q));

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: table-driven frames plus hand-written overrun, false-start, reset and
// back-to-back sequences; received bytes are checked against a scoreboard queue.
module tb_uart_receiver;

    localparam int unsigned OS = 16;
`ifdef RX_GLITCH_FILTER_EN
    localparam int FiltExtra = 1;
    localparam logic [7:0] GlitchExp = 8'h00;
`else
    localparam int FiltExtra = 0;
    localparam logic [7:0] GlitchExp = 8'h08;
`endif
    // Sync (2) + start detect to mid-start (OS/2) + 9 bit periods + register (1).
    localparam int Lat = 2 + OS / 2 + 9 * OS + 1 + FiltExtra;

    logic       bclk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic       rd;
    logic [7:0] d_out;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];

    uart_receiver #(
        .OVERSAMPLE(OS)
    ) dut (
        .bclk       (bclk),
        .reset      (reset),
        .rx_in      (rx_in),
        .rd         (rd),
        .d_out      (d_out),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .rx_busy    (rx_busy)
    );

    always #5 bclk = ~bclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    // One bit period; with glitch set, the line inverts for one cycle at mid-bit.
    task automatic send_bit(input logic v, input int glitch);
        for (int i = 0; i < OS; i++) begin
            if (glitch != 0 && i == OS / 2) begin
                rx_in = ~v;
            end else begin
                rx_in = v;
            end
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gbit);
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], (i == gbit) ? 1 : 0);
        end
        send_bit(stop, 0);
    endtask

    task automatic wait_ready(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (rx_ready === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic check_lat(input int cyc);
        logic ok;
        ok = (cyc >= Lat - 1) && (cyc <= Lat + 1);
        chk("ready_latency", ok ? Lat : cyc, Lat);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic ferr);
        exp_t e;
        e.data = d;
        e.ferr = ferr;
        sb_q.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk("d_out", d_out, e.data);
            chk("frame_err", frame_err, e.ferr);
        end
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    // Full single-frame transaction: latency, byte, flags, idle, then read-back clears.
    task automatic run_frame(input logic [7:0] d, input logic stop, input int gbit,
                             input logic [7:0] exp_d);
        int cyc;
        push_exp(exp_d, ~stop);
        fork
            begin
                send_frame(d, stop, gbit);
            end
            begin
                wait_ready(cyc);
            end
        join
        check_lat(cyc);
        check_sb();
        chk("no_overrun", overrun_err, 1'b0);
        chk("idle_after_frame", rx_busy, 1'b0);
        rx_in = 1'b1;
        pulse_rd();
        chk("rd_clears_ready", rx_ready, 1'b0);
        chk("rd_clears_ferr", frame_err, 1'b0);
        chk("rd_holds_d_out", d_out, exp_d);
        repeat (3) tick();
    endtask

    initial begin
        int   cyc;
        logic seen;

        vecs[0] = '{data: 8'hA5, stop: 1'b1};
        vecs[1] = '{data: 8'h3C, stop: 1'b0};
        vecs[2] = '{data: 8'h00, stop: 1'b1};
        vecs[3] = '{data: 8'hFF, stop: 1'b1};
        vecs[4] = '{data: 8'h81, stop: 1'b0};
        vecs[5] = '{data: 8'h6E, stop: 1'b1};

        reset = 1'b1;
        rx_in = 1'b1;
        rd    = 1'b0;
        repeat (3) tick();
        chk("reset_d_out", d_out, 8'h00);
        chk("reset_rx_ready", rx_ready, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        chk("reset_overrun", overrun_err, 1'b0);
        chk("reset_busy", rx_busy, 1'b0);
        reset = 1'b0;
        repeat (4) tick();

        pulse_rd();
        chk("rd_without_ready", rx_ready, 1'b0);

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].data, vecs[v].stop, -1, vecs[v].data);
        end

        // Overrun: second byte arrives while the first is unread and is dropped.
        push_exp(8'h11, 1'b0);
        fork
            begin
                send_frame(8'h11, 1'b1, -1);
            end
            begin
                wait_ready(cyc);
            end
        join
        check_lat(cyc);
        check_sb();
        send_frame(8'h22, 1'b1, -1);
        chk("overrun_ready", rx_ready, 1'b1);
        chk("overrun_keeps_old", d_out, 8'h11);
        chk("overrun_flag", overrun_err, 1'b1);
        chk("overrun_ferr", frame_err, 1'b0);
        pulse_rd();
        chk("overrun_rd_ready", rx_ready, 1'b0);
        chk("overrun_rd_clear", overrun_err, 1'b0);
        repeat (3) tick();

        // False start: 4-cycle low pulse.
        seen  = 1'b0;
        rx_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rx_busy) seen = 1'b1;
        end
        rx_in = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rx_busy) seen = 1'b1;
        end
        chk("false_start_busy_seen", seen, 1'b1);
        chk("false_start_idle", rx_busy, 1'b0);
        chk("false_start_no_ready", rx_ready, 1'b0);

        // Reset in the middle of data bit 4 of 0xFF.
        fork
            begin
                send_frame(8'hFF, 1'b1, -1);
            end
            begin
                repeat (OS * 5 + OS / 2) tick();
                chk("midframe_busy", rx_busy, 1'b1);
                reset = 1'b1;
                #1;
                chk("midframe_reset_busy", rx_busy, 1'b0);
                chk("midframe_reset_d_out", d_out, 8'h00);
                tick();
                tick();
                reset = 1'b0;
            end
        join
        repeat (4) tick();
        chk("after_abort_no_ready", rx_ready, 1'b0);
        chk("after_abort_idle", rx_busy, 1'b0);
        run_frame(8'h5A, 1'b1, -1, 8'h5A);

        // Back-to-back 0x00 then 0xFF; rd lands in the cycle 0xFF completes.
        push_exp(8'h00, 1'b0);
        push_exp(8'hFF, 1'b0);
        fork
            begin
                send_frame(8'h00, 1'b1, -1);
                send_frame(8'hFF, 1'b1, -1);
            end
            begin
                wait_ready(cyc);
                check_lat(cyc);
                check_sb();
                repeat (OS * 10 - 1) tick();
                chk("b2b_first_held", d_out, 8'h00);
                pulse_rd();
                chk("b2b_ready", rx_ready, 1'b1);
                chk("b2b_no_overrun", overrun_err, 1'b0);
                check_sb();
            end
        join
        pulse_rd();
        chk("b2b_rd_clears", rx_ready, 1'b0);
        repeat (3) tick();

        // One-cycle high glitch at mid-bit of data bit 3 of 0x00.
        run_frame(8'h00, 1'b1, 3, GlitchExp);

        chk("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
